// File: rtl/led_mmio_ctrl_if.sv
// ----------------------------------------------------------------------------
// led_mmio_ctrl_if
//   Load/store bus between the core's data-memory port and the LED peripheral.
//   master : core side (drives request, receives ready/rdata/rvalid)
//   slave  : peripheral side
//   bus_valid  request this cycle        bus_ready  accepted (combinational)
//   bus_we     1 = store, 0 = load       bus_addr   byte address
//   bus_wdata  store data                bus_wstrb  store byte enables
//   bus_rdata  load data                 bus_rvalid one-cycle load-data pulse
// ----------------------------------------------------------------------------
interface led_mmio_ctrl_if;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rdata, bus_rvalid
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rdata, bus_rvalid
   );
endinterface

// File: rtl/led_mmio_ctrl.sv
// ----------------------------------------------------------------------------
// led_mmio_ctrl
//   Memory-mapped LED output peripheral. Software sets, clears, toggles and
//   blinks LEDs through a 32-byte register window; a tick prescaler and a
//   period counter generate the blink phase.
//   CLOCK_50 : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : load/store slave port (led_mmio_ctrl_if.slave)
//   led      : registered LED drive, active-high
//   Register map (offset = addr[4:2]):
//     0x00 DATA  RW   0x04 SET  W1S   0x08 CLR  W1C   0x0C TGL  W1T
//     0x10 BMASK RW   0x14 PERIOD RW  0x18 STATUS RO  0x1C reserved
// ----------------------------------------------------------------------------
module led_mmio_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int unsigned LED_W      = 18,
   parameter int unsigned PRESCALE   = 50000,
   parameter logic [15:0] DEF_PERIOD = 16'd500
) (
   input  logic               CLOCK_50,
   input  logic               rst,
   led_mmio_ctrl_if.slave     bus,
   output logic [LED_W-1:0]   led
);

   localparam int unsigned     PRE_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   localparam logic [2:0] OFF_DATA   = 3'd0;
   localparam logic [2:0] OFF_SET    = 3'd1;
   localparam logic [2:0] OFF_CLR    = 3'd2;
   localparam logic [2:0] OFF_TGL    = 3'd3;
   localparam logic [2:0] OFF_BMASK  = 3'd4;
   localparam logic [2:0] OFF_PERIOD = 3'd5;
   localparam logic [2:0] OFF_STATUS = 3'd6;

   // State
   logic [LED_W-1:0] data_q,     data_d;
   logic [LED_W-1:0] bmask_q,    bmask_d;
   logic [15:0]      period_q,   period_d;
   logic [PRE_W-1:0] pre_q,      pre_d;
   logic [15:0]      tick_cnt_q, tick_cnt_d;
   logic             phase_q,    phase_d;
   logic [LED_W-1:0] led_q,      led_d;
   logic [31:0]      rdata_q,    rdata_d;
   logic             rvalid_q,   rvalid_d;

   // Decode
   logic [31:0]      rel_addr;
   logic             sel;
   logic [2:0]       off;
   logic             accept;
   logic             wr_acc;
   logic             rd_acc;
   logic [31:0]      wmask;
   logic [31:0]      eff;
   logic [LED_W-1:0] eff_led;
   logic [LED_W-1:0] mask_led;
   logic             tick;
   logic [31:0]      rd_val;
   logic             unused_bits;

   // Window decode; subtraction keeps it correct for any BASE_ADDR alignment
   assign rel_addr = bus.bus_addr - BASE_ADDR;
   assign sel      = (bus.bus_addr >= BASE_ADDR) && (rel_addr[31:5] == 27'd0);
   assign off      = rel_addr[4:2];

   // Reset gating keeps a request on the reset-release edge from being accepted
   assign accept   = bus.bus_valid & sel & ~rst;
   assign wr_acc   = accept &  bus.bus_we;
   assign rd_acc   = accept & ~bus.bus_we;

   assign wmask    = {{8{bus.bus_wstrb[3]}}, {8{bus.bus_wstrb[2]}},
                      {8{bus.bus_wstrb[1]}}, {8{bus.bus_wstrb[0]}}};
   assign eff      = bus.bus_wdata & wmask;
   assign eff_led  = eff[LED_W-1:0];
   assign mask_led = wmask[LED_W-1:0];

   assign tick     = (pre_q == PRE_MAX);

   assign unused_bits = ^{rel_addr[1:0], eff, wmask};

   // Read mux over current register contents
   always_comb begin
      rd_val = 32'd0;
      case (off)
         OFF_DATA:   rd_val = 32'(data_q);
         OFF_BMASK:  rd_val = 32'(bmask_q);
         OFF_PERIOD: rd_val = {16'd0, period_q};
         OFF_STATUS: rd_val = {15'd0, phase_q, tick_cnt_q};
         default:    rd_val = 32'd0;
      endcase
   end

   // Next-state for registers, blink timebase and bus response
   always_comb begin
      data_d     = data_q;
      bmask_d    = bmask_q;
      period_d   = period_q;
      pre_d      = tick ? '0 : pre_q + PRE_W'(1);
      tick_cnt_d = tick_cnt_q;
      phase_d    = phase_q;
      rdata_d    = rdata_q;
      rvalid_d   = rd_acc;

      // Blink timebase
      if (period_q == 16'd0) begin
         tick_cnt_d = 16'd0;
         phase_d    = 1'b0;
      end else if (tick) begin
         if (tick_cnt_q == period_q - 16'd1) begin
            tick_cnt_d = 16'd0;
            phase_d    = ~phase_q;
         end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
         end
      end

      // Register writes
      if (wr_acc) begin
         case (off)
            OFF_DATA:   data_d  = (data_q  & ~mask_led) | eff_led;
            OFF_SET:    data_d  = data_q | eff_led;
            OFF_CLR:    data_d  = data_q & ~eff_led;
            OFF_TGL:    data_d  = data_q ^ eff_led;
            OFF_BMASK:  bmask_d = (bmask_q & ~mask_led) | eff_led;
            OFF_PERIOD: begin
               // Restart the timebase; phase holds unless blinking is disabled
               period_d   = (period_q & ~wmask[15:0]) | eff[15:0];
               pre_d      = '0;
               tick_cnt_d = 16'd0;
               phase_d    = (period_d == 16'd0) ? 1'b0 : phase_q;
            end
            default: ;
         endcase
      end

      if (rd_acc) begin
         rdata_d = rd_val;
      end

      // led follows the registers with one cycle of latency
      led_d = data_q ^ (bmask_q & {LED_W{phase_q}});
   end

   // State registers
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         data_q     <= '0;
         bmask_q    <= '0;
         period_q   <= DEF_PERIOD;
         pre_q      <= '0;
         tick_cnt_q <= 16'd0;
         phase_q    <= 1'b0;
         led_q      <= '0;
         rdata_q    <= 32'd0;
         rvalid_q   <= 1'b0;
      end else begin
         data_q     <= data_d;
         bmask_q    <= bmask_d;
         period_q   <= period_d;
         pre_q      <= pre_d;
         tick_cnt_q <= tick_cnt_d;
         phase_q    <= phase_d;
         led_q      <= led_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign bus.bus_ready  = accept;
   assign bus.bus_rdata  = rdata_q;
   assign bus.bus_rvalid = rvalid_q;
   assign led            = led_q;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_mmio_ctrl
//   Directed bench for led_mmio_ctrl (PRESCALE=4, DEF_PERIOD=3). Loads push
//   their expected data into a queue; a monitor pops and compares on every
//   bus_rvalid. LED and bus_ready values are compared directly.
// ----------------------------------------------------------------------------
module tb_led_mmio_ctrl;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [17:0] led;

   always #5 clk = ~clk;

   led_mmio_ctrl_if bus_if ();

   led_mmio_ctrl #(
      .BASE_ADDR  (BASE),
      .LED_W      (18),
      .PRESCALE   (4),
      .DEF_PERIOD (16'd3)
   ) dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .bus      (bus_if.slave),
      .led      (led)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   string       name_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every rvalid must match the oldest outstanding load
   always @(negedge clk) begin
      if (bus_if.bus_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            check(name_q.pop_front(), bus_if.bus_rdata, exp_q.pop_front());
         end
      end
   end

   // All tasks start and end on a falling edge
   task automatic idle();
      bus_if.bus_valid = 1'b0;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_wstrb = 4'd0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b1;
      bus_if.bus_addr  = BASE + 32'(off);
      bus_if.bus_wdata = d;
      bus_if.bus_wstrb = s;
      @(negedge clk);
   endtask

   task automatic rd(input logic [4:0] off, input logic [31:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = BASE + 32'(off);
      bus_if.bus_wdata = 32'd0;
      bus_if.bus_wstrb = 4'd0;
      #1 check("ready_in_window", 32'(bus_if.bus_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic oob(input logic [31:0] a, input logic we, input string nm);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = we;
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = 32'hFFFF_FFFF;
      bus_if.bus_wstrb = 4'hF;
      #1 check(nm, 32'(bus_if.bus_ready), 32'd0);
      @(negedge clk);
   endtask

   task automatic chk_led(input string nm, input logic [17:0] e);
      check(nm, 32'(led), 32'(e));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.bus_addr  = 32'd0;
      bus_if.bus_wdata = 32'd0;
      idle();

      // 1: reset
      rst = 1'b1;
      wait_n(3);
      chk_led("rst_led", 18'h0);
      check("rst_rvalid", 32'(bus_if.bus_rvalid), 32'd0);
      rst = 1'b0;
      rd(5'h14, 32'd3, "rd_period_rst");
      rd(5'h00, 32'd0, "rd_data_rst");
      idle();

      // 2: DATA/SET/CLR/TGL, one-cycle led latency
      wr(5'h00, 32'h0003_FFFF, 4'b0001); idle();
      chk_led("led_latency", 18'h0);
      wait_n(1); chk_led("led_data_b0", 18'h000FF);
      wr(5'h04, 32'h100, 4'hF); idle();
      wait_n(1); chk_led("led_set", 18'h001FF);
      wr(5'h08, 32'h1, 4'hF); idle();
      wait_n(1); chk_led("led_clr", 18'h001FE);
      wr(5'h0C, 32'h3, 4'hF); idle();
      wait_n(1); chk_led("led_tgl", 18'h001FD);
      rd(5'h00, 32'h1FD, "rd_data");
      rd(5'h04, 32'h0,   "rd_set_zero");
      rd(5'h1C, 32'h0,   "rd_rsvd_zero");
      idle();
      wr(5'h1C, 32'hFFFF_FFFF, 4'hF); idle();
      rd(5'h00, 32'h1FD, "rd_data_after_rsvd"); idle();
      wr(5'h00, 32'hFFFF_FFFF, 4'b1100); idle();
      rd(5'h00, 32'h301FD, "rd_data_upper_strb"); idle();

      // 3: blink with BMASK=3, PERIOD=3 restarted at a known edge E0
      wr(5'h00, 32'h0, 4'hF);
      wr(5'h10, 32'h3, 4'hF);
      wr(5'h14, 32'h0, 4'hF);
      wr(5'h14, 32'h3, 4'b0011);
      idle();                                         // E0+0.5
      chk_led("blink_start", 18'h0);
      wait_n(11); chk_led("blink_pre_t1", 18'h0);     // E0+11.5
      wait_n(2);  chk_led("blink_t1", 18'h3);         // E0+13.5
      rd(5'h18, 32'h0001_0000, "rd_status_phase1"); idle();
      wait_n(10); chk_led("blink_pre_t2", 18'h3);     // E0+24.5
      wait_n(1);  chk_led("blink_t2", 18'h0);         // E0+25.5
      wait_n(4);
      rd(5'h18, 32'h0000_0001, "rd_status_cnt1"); idle();
      wait_n(7);  chk_led("blink_t3", 18'h3);         // E0+37.5, phase 1

      // 4: PERIOD=0 mid-phase-1, then PERIOD=2
      wr(5'h14, 32'h0, 4'hF); idle();
      chk_led("p0_latency", 18'h3);
      wait_n(1);  chk_led("p0_led_data", 18'h0);
      wait_n(20); chk_led("p0_led_held", 18'h0);
      rd(5'h18, 32'h0, "rd_status_disabled"); idle();
      wr(5'h14, 32'h2, 4'b0001); idle();              // E2+0.5
      wait_n(8); chk_led("p2_pre_toggle", 18'h0);
      wait_n(1); chk_led("p2_toggle", 18'h3);
      rd(5'h14, 32'h2, "rd_period2"); idle();

      // 5: out-of-window accesses, then back-to-back loads
      oob(BASE + 32'h20, 1'b1, "oob_wr_hi");
      oob(32'h0,         1'b1, "oob_wr_zero");
      oob(BASE + 32'h20, 1'b0, "oob_rd_hi");
      oob(BASE - 32'h4,  1'b0, "oob_rd_below");
      idle();
      rd(5'h00, 32'h0, "b2b_data");
      rd(5'h10, 32'h3, "b2b_bmask");
      rd(5'h14, 32'h2, "b2b_period");
      idle();

      // 6: async reset during a load accept and mid-blink
      wr(5'h00, 32'h5A5, 4'hF); idle();
      wait_n(2);
      check("led_pre_rst", 32'(led & 18'h3FFFC), 32'h5A4);
      bus_if.bus_valid = 1'b1;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = BASE;
      #2 rst = 1'b1;
      #1;
      chk_led("rst_async_led", 18'h0);
      check("rst_async_rvalid", 32'(bus_if.bus_rvalid), 32'd0);
      check("rst_ready", 32'(bus_if.bus_ready), 32'd0);
      @(negedge clk);
      check("rst_rvalid_after_edge", 32'(bus_if.bus_rvalid), 32'd0);
      idle();
      wait_n(2);
      rst = 1'b0;
      wait_n(1); chk_led("post_rst_led", 18'h0);
      rd(5'h00, 32'h0, "rd_data_post_rst");
      rd(5'h10, 32'h0, "rd_bmask_post_rst");
      rd(5'h14, 32'h3, "rd_period_post_rst");
      idle();

      wait_n(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
